bitwise_logic_unit: RTL
=======================

Name: bitwise_logic_unit

Overview:
- Parametrised, registered successor to the fixed 8-bit AND/NAND/XOR/XNOR slice.
- Selects one of 8 bitwise ops per transaction on WIDTH-bit operands and can chain results through an internal accumulator.
- Computes zero, parity and popcount flags.
- Buffers results in a DEPTH-entry output FIFO behind valid/ready handshakes; sits between the operand source and any consumer that can stall.

Parameters:
- WIDTH, 8, operand/result bit width (>=2)
- DEPTH, 2, output FIFO entries (power of 2, >=2)
- CNT_W, $clog2(WIDTH+1), popcount width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept a transaction
- in_op  in  3  operation select
- in_acc  in  1  use accumulator as B operand and write the result back
- in_clr  in  1  with in_acc: treat accumulator as 0 for this op
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored when in_acc=1)
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer takes head
- out_y  out  WIDTH  head result
- out_zero  out  1  head result == 0
- out_parity  out  1  XOR-reduction of head result
- out_ones  out  CNT_W  popcount of head result
- acc_q  out  WIDTH  current accumulator value
- level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFO empty, level=0, out_valid=0, out_y/out_zero/out_parity/out_ones=0, acc_q=0, in_ready=0 while asserted. A transaction mid-flight is discarded, with no partial writes.
- After reset release, in_ready = (level != DEPTH). It is a combinational function of registered occupancy and does not depend on out_ready; there is no pass-through when full.
- Accept = in_valid & in_ready at the rising edge. Pop = out_valid & out_ready.
- Operand B_eff: in_acc=0 -> in_b; in_acc=1, in_clr=0 -> acc_q; in_acc=1, in_clr=1 -> 0. in_clr is ignored when in_acc=0.
- Op codes, applied bitwise over WIDTH to A and B_eff:
  - 000 AND, 001 NAND, 010 XOR, 011 XNOR
  - 100 OR, 101 NOR, 110 PASS_A, 111 NOT_A
- On accept, {result, zero, parity, popcount} is written to the FIFO tail.
- If in_acc=1, acc_q <= result on the same edge. acc_q is unchanged otherwise, including when nothing is accepted.
- Latency: accepted at edge N -> visible at head with out_valid=1 after edge N. There is no same-cycle bypass, even when empty.
- Head outputs are driven from FIFO storage. When empty, out_y/flags read 0.
- Head data is stable while out_valid=1 and out_ready=0.
- Simultaneous accept and pop: level unchanged, both pointers advance. Legal at any level < DEPTH. When full, only pop occurs.
- Pointers wrap modulo DEPTH. level is a separate counter 0..DEPTH.
- Results are in strict acceptance order.
- No arithmetic carries. Popcount is an unsigned sum fitting CNT_W with no overflow.

Decomposition:
- Package logic_unit_pkg holds:
  - op_e enum (3-bit codes above)
  - function lu_apply(op, a, b)
  - function lu_popcount(v)
  - width-generic flag helpers
- One sub-module: lu_fifo, a synchronous DEPTH x (WIDTH+2+CNT_W) FIFO with push/pop/level/full/empty and async active-low reset. Top level holds the op datapath, accumulator and handshake glue.

Test Plan:
- Op sweep, WIDTH=8, a=8'hCA, b=8'h5C, op 0..7, out_ready=1 -> out_y = 48, B7, 96, 69, DE, 21, CA, 35. out_ones for AND 48 = 2; parity(48)=0. Each result appears 1 cycle after accept.
- Accumulate chain: in_acc=1, in_clr=1, op=OR, a=8'h0F -> y=0F, acc=0F. Then in_acc=1, op=XOR, a=8'hFF -> y=F0, acc=F0. Then in_acc=0, op=AND, a=FF, b=01 -> y=01, acc stays F0.
- Backpressure, DEPTH=2, out_ready=0: push 3 offers -> 2 accepted, level=2, in_ready=0, third held. Raise out_ready -> head pops in order, third accepted on the next edge once level<2.
- Simultaneous push/pop at level=1: level stays 1, order preserved over 16 random transactions checked against a model.
- Zero flag: op=XOR, a=b=8'hA5 -> y=00, out_zero=1, parity=0, ones=0. op=NOR, a=b=00 -> y=FF, ones=8, parity=0.
- Async reset mid-stream: fill FIFO and set acc=F0, drop reset between edges -> out_valid, level and acc_q go to 0 immediately. After release, in_ready=1 and the first accepted result appears 1 cycle later.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the bitwise logic unit.
// Helpers take and return LU_MAX_W-bit vectors so they serve any WIDTH up to
// LU_MAX_W. Callers zero-extend operands and truncate results to WIDTH.
// Zero-extension leaves the zero, parity and popcount flags unchanged.
package logic_unit_pkg;

  localparam int unsigned LU_MAX_W = 64;
  localparam int unsigned LU_CNT_W = $clog2(LU_MAX_W + 1);

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_NAND   = 3'b001,
    OP_XOR    = 3'b010,
    OP_XNOR   = 3'b011,
    OP_OR     = 3'b100,
    OP_NOR    = 3'b101,
    OP_PASS_A = 3'b110,
    OP_NOT_A  = 3'b111
  } op_e;

  // Apply one bitwise op. Upper bits above the caller's WIDTH are don't-care.
  function automatic logic [LU_MAX_W-1:0] lu_apply(
    input op_e                 op,
    input logic [LU_MAX_W-1:0] a,
    input logic [LU_MAX_W-1:0] b
  );
    logic [LU_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:    r = a & b;
      OP_NAND:   r = ~(a & b);
      OP_XOR:    r = a ^ b;
      OP_XNOR:   r = ~(a ^ b);
      OP_OR:     r = a | b;
      OP_NOR:    r = ~(a | b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Unsigned count of set bits.
  function automatic logic [LU_CNT_W-1:0] lu_popcount(input logic [LU_MAX_W-1:0] v);
    logic [LU_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(LU_MAX_W); i++) begin
      cnt = cnt + LU_CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic lu_is_zero(input logic [LU_MAX_W-1:0] v);
    return ~|v;
  endfunction

  function automatic logic lu_parity(input logic [LU_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lu_fifo.sv
// Synchronous result FIFO, DEPTH x DW, with a separate occupancy counter.
// Ports: clk, reset (async active-low), push/wdata (tail write), pop (head
// advance), rdata (head entry), level (0..DEPTH), full, empty.
// The caller sees push ignored when full and pop ignored when empty.
module lu_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DW-1:0]                wdata,
  input  logic                         pop,
  output logic [DW-1:0]                rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign rdata   = r_mem[r_rd_ptr];
  assign level   = r_level;

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with accumulator and output FIFO.
// Ports: clk, reset (async active-low); in_valid/in_ready/in_op/in_acc/in_clr/
// in_a/in_b is the operand handshake. out_valid/out_ready/out_y/out_zero/
// out_parity/out_ones is the head of the result FIFO. acc_q is the
// accumulator and level is the FIFO occupancy. WIDTH must not exceed LU_MAX_W.
module bitwise_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic                         in_acc,
  input  logic                         in_clr,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_y,
  output logic                         out_zero,
  output logic                         out_parity,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic [WIDTH-1:0]             acc_q,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] ones;
  } res_t;

  localparam int unsigned RES_W = $bits(res_t);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_y;
  logic             w_accept;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  res_t             w_res;
  res_t             w_head;
  logic [RES_W-1:0] w_rdata;

  // Held low during reset so nothing is accepted mid-reset.
  assign in_ready = reset & ~w_full;
  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  // B operand select; in_clr only matters when chaining through the accumulator.
  always_comb begin
    w_b_eff = in_b;
    if (in_acc) begin
      w_b_eff = in_clr ? '0 : r_acc;
    end
  end

  // Result and flags, computed from the WIDTH-bit result only.
  always_comb begin
    w_y          = WIDTH'(lu_apply(op_e'(in_op), LU_MAX_W'(in_a), LU_MAX_W'(w_b_eff)));
    w_res.y      = w_y;
    w_res.zero   = lu_is_zero(LU_MAX_W'(w_y));
    w_res.parity = lu_parity(LU_MAX_W'(w_y));
    w_res.ones   = CNT_W'(lu_popcount(LU_MAX_W'(w_y)));
  end

  // Accumulator captures the result only for accepted chained transactions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (w_accept && in_acc) begin
      r_acc <= w_y;
    end
  end

  assign acc_q = r_acc;

  lu_fifo #(
    .DW    (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .wdata (w_res),
    .pop   (w_pop),
    .rdata (w_rdata),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Head is forced to zero when empty so stale storage never shows.
  assign w_head     = w_rdata;
  assign out_valid  = ~w_empty;
  assign out_y      = w_empty ? '0 : w_head.y;
  assign out_zero   = w_empty ? 1'b0 : w_head.zero;
  assign out_parity = w_empty ? 1'b0 : w_head.parity;
  assign out_ones   = w_empty ? '0 : w_head.ones;

endmodule
